conv3x3_stream: RTL and testbench

Streaming 3x3 neighbourhood filter for raster-order pixel streams, parametrised in image size, channel count and channel width, with a run-time selectable kernel (passthrough, box blur, Gaussian, sharpen). It sits between the UART pixel assembler and the display frame buffer. It replaces random-access convolution over a frame BRAM with two internal line buffers and valid/ready handshakes on both sides.

---
 rtl/conv3x3_stream.sv | 220 ++++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// Raster-order 3x3 neighbourhood filter (passthrough/box/Gaussian/sharpen) with two line buffers.
// Outputs lag inputs by IMG_W+1 pixels; FLUSH drains the trailing border outputs without input.
module conv3x3_stream #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int CH      = 3,
  parameter int CH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*CH_BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*CH_BITS-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  frame_done,
  output logic                  busy
);

  // state | meaning
  // RUN   | accepting input pixels; an output is loaded for every step with p >= IMG_W+1
  // FLUSH | input closed; stepping the window to emit the last IMG_W+1 border outputs

  localparam int DW   = CH * CH_BITS;
  localparam int CW   = CH_BITS + 4;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H + 1);
  localparam int PW   = $clog2(NPIX + IMG_W + 2);

  localparam logic [PW-1:0] P_FIRST_OUT = PW'(IMG_W + 1);
  localparam logic [PW-1:0] P_LAST_IN   = PW'(NPIX - 1);
  localparam logic [PW-1:0] P_END       = PW'(NPIX + IMG_W + 1);
  localparam logic [XW-1:0] X_LAST      = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(IMG_H - 1);
  localparam logic [CW-1:0] PIX_MAX     = CW'((1 << CH_BITS) - 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  function automatic logic [CH_BITS-1:0] filt(
    input logic [1:0]         m,
    input logic [CH_BITS-1:0] nw, n, ne, w, c, e, sw, s, se
  );
    logic [CW-1:0]        sum9, quot, gs, c5;
    logic signed [CW-1:0] sh;
    logic [CH_BITS-1:0]   r;
    sum9 = CW'(nw) + CW'(n) + CW'(ne) + CW'(w) + CW'(c) + CW'(e) + CW'(sw) + CW'(s) + CW'(se);
    quot = sum9 / CW'(9);
    gs   = (CW'(c) << 2) + ((CW'(n) + CW'(s) + CW'(e) + CW'(w)) << 1)
         + CW'(nw) + CW'(ne) + CW'(sw) + CW'(se);
    c5   = (CW'(c) << 2) + CW'(c);
    sh   = $signed(c5) - $signed(CW'(n)) - $signed(CW'(s)) - $signed(CW'(e)) - $signed(CW'(w));
    case (m)
      2'd1: r = quot[CH_BITS-1:0];
      2'd2: r = gs[CW-1:4];
      2'd3: begin
        if (sh[CW-1])                   r = '0;
        else if (sh > $signed(PIX_MAX)) r = '1;
        else                            r = sh[CH_BITS-1:0];
      end
      default: r = c;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [XW-1:0]     x_q, x_d;
  logic [XW-1:0]     qx_q, qx_d;
  logic [YW-1:0]     qy_q, qy_d;
  logic [1:0]        mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              fd_q, fd_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eol_q, out_eol_d;
  logic              out_last_q, out_last_d;

  logic [DW-1:0]     lb_a_q [0:IMG_W-1];
  logic [DW-1:0]     lb_b_q [0:IMG_W-1];
  logic [DW-1:0]     win_q  [0:2][0:2];
  logic [DW-1:0]     col    [0:2];
  logic [DW-1:0]     nwin   [0:2][0:2];
  logic [DW-1:0]     filt_data;

  logic accept, flush_step, step, produce, out_hs, done, border;

  assign in_ready   = (state_q == S_RUN) && ((p_q < P_FIRST_OUT) || !out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign flush_step = (state_q == S_FLUSH) && (p_q != P_END) && (!out_valid_q || out_ready);
  assign step       = accept || flush_step;
  assign produce    = step && (p_q >= P_FIRST_OUT);
  assign out_hs     = out_valid_q && out_ready;
  assign done       = out_hs && out_last_q;
  assign border     = (qx_q == '0) || (qx_q == X_LAST) || (qy_q == '0) || (qy_q == Y_LAST);

  // Column entering the window: rows y-2, y-1, y at column x; FLUSH feeds a dummy bottom row.
  always_comb begin
    col[0] = lb_b_q[x_q];
    col[1] = lb_a_q[x_q];
    col[2] = (state_q == S_RUN) ? in_data : '0;
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win_q[r][1];
      nwin[r][1] = win_q[r][2];
      nwin[r][2] = col[r];
    end
  end

  always_comb begin
    filt_data = '0;
    for (int i = 0; i < CH; i++) begin
      filt_data[i*CH_BITS +: CH_BITS] = filt(mode_q,
        nwin[0][0][i*CH_BITS +: CH_BITS], nwin[0][1][i*CH_BITS +: CH_BITS], nwin[0][2][i*CH_BITS +: CH_BITS],
        nwin[1][0][i*CH_BITS +: CH_BITS], nwin[1][1][i*CH_BITS +: CH_BITS], nwin[1][2][i*CH_BITS +: CH_BITS],
        nwin[2][0][i*CH_BITS +: CH_BITS], nwin[2][1][i*CH_BITS +: CH_BITS], nwin[2][2][i*CH_BITS +: CH_BITS]);
    end
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    x_d         = x_q;
    qx_d        = qx_q;
    qy_d        = qy_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    fd_d        = done;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_last_d  = out_last_q;

    if (accept && (p_q == '0)) mode_d = mode;
    if (accept) busy_d = 1'b1;

    if (done) begin
      state_d = S_RUN;
      p_d     = '0;
      x_d     = '0;
      qx_d    = '0;
      qy_d    = '0;
      busy_d  = 1'b0;
    end else if (step) begin
      p_d = p_q + PW'(1);
      x_d = (x_q == X_LAST) ? '0 : x_q + XW'(1);
      if (accept && (p_q == P_LAST_IN)) state_d = S_FLUSH;
    end

    if (produce) begin
      out_valid_d = 1'b1;
      out_data_d  = border ? nwin[1][1] : filt_data;
      out_sof_d   = (qx_q == '0) && (qy_q == '0);
      out_eol_d   = (qx_q == X_LAST);
      out_last_d  = (qx_q == X_LAST) && (qy_q == Y_LAST);
      qx_d        = (qx_q == X_LAST) ? '0 : qx_q + XW'(1);
      if (qx_q == X_LAST) qy_d = qy_q + YW'(1);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      p_q         <= '0;
      x_q         <= '0;
      qx_q        <= '0;
      qy_q        <= '0;
      mode_q      <= '0;
      busy_q      <= 1'b0;
      fd_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      x_q         <= x_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      fd_q        <= fd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffers and window hold pixel data only; row 0 is all border so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b_q[x_q] <= lb_a_q[x_q];
      lb_a_q[x_q] <= in_data;
    end
    if (step) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= nwin[r][c];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x6 frame: ramp, impulse kernels, stalls,
// mode sampling with back-to-back frames, and mid-frame reset.
module tb_conv3x3_stream;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int CH = 3;
  localparam int CB = 4;
  localparam int DW = CH * CB;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .CH(CH), .CH_BITS(CB)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done), .busy(busy)
  );

  logic [DW-1:0] in_pix  [0:2*N-1];
  logic [1:0]    in_md   [0:2*N-1];
  logic [DW-1:0] exp_pix [0:2*N-1];
  logic [DW-1:0] got_pix [0:2*N-1];
  logic          got_sof [0:2*N-1];
  logic          got_eol [0:2*N-1];

  int n_out, n_fd, first_valid_cyc, acc9_cyc, fd_cyc, next_frame_acc_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference filter written directly from the kernel definitions on a whole-frame array.
  function automatic logic [DW-1:0] model(input int base, input int x, input int y, input logic [1:0] m);
    logic [DW-1:0] r;
    logic [DW-1:0] pv;
    int v [0:2][0:2];
    int res, sum, xx, yy;
    r = '0;
    for (int ch = 0; ch < CH; ch++) begin
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          xx = x + dx;
          yy = y + dy;
          if (xx >= 0 && xx < W && yy >= 0 && yy < H) begin
            pv = in_pix[base + yy*W + xx];
            v[dy+1][dx+1] = int'(pv[ch*CB +: CB]);
          end else
            v[dy+1][dx+1] = 0;
        end
      if (x == 0 || x == W-1 || y == 0 || y == H-1 || m == 2'd0)
        res = v[1][1];
      else if (m == 2'd1) begin
        sum = 0;
        for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) sum += v[a][b];
        res = sum / 9;
      end else if (m == 2'd2)
        res = (4*v[1][1] + 2*(v[0][1] + v[2][1] + v[1][0] + v[1][2])
               + v[0][0] + v[0][2] + v[2][0] + v[2][2]) / 16;
      else begin
        res = 5*v[1][1] - v[0][1] - v[2][1] - v[1][0] - v[1][2];
        if (res < 0)  res = 0;
        if (res > 15) res = 15;
      end
      r[ch*CB +: CB] = 4'(res);
    end
    return r;
  endfunction

  // Hand-computed outputs for a single R=15 pixel at (3,2).
  function automatic logic [DW-1:0] imp_exp(input int m, input int x, input int y);
    int dx, dy;
    logic [DW-1:0] r;
    dx = x - 3;
    dy = y - 2;
    r  = 12'h000;
    case (m)
      1: if (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1) r = 12'h100;
      2: begin
        if (dx == 0 && dy == 0) r = 12'h300;
        else if ((dx == 0 && (dy == 1 || dy == -1)) || (dy == 0 && (dx == 1 || dx == -1))) r = 12'h100;
      end
      default: if (dx == 0 && dy == 0) r = 12'hF00;
    endcase
    return r;
  endfunction

  task automatic run_stream(input int npix, input int stall_period, input int nframes);
    int idx, cyc, last_hs;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    idx = 0; cyc = 0; last_hs = -10; prev_stall = 1'b0; prev_data = '0;
    n_out = 0; n_fd = 0; first_valid_cyc = -1; acc9_cyc = -1; fd_cyc = -1; next_frame_acc_cyc = -1;
    while (n_fd < nframes && cyc < 3000) begin
      out_ready = (stall_period <= 1) || (cyc % stall_period == 0);
      in_valid  = (idx < npix);
      in_data   = (idx < npix) ? in_pix[idx] : '0;
      mode      = (idx < npix) ? in_md[idx] : 2'd0;
      #1;
      if (frame_done) begin
        n_fd++;
        chk("frame_done_lat", 32'(cyc), 32'(last_hs + 1));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("outs_at_done", 32'(n_out), 32'(n_fd * N));
        if (n_fd == 1) fd_cyc = cyc;
      end
      if (prev_stall && out_valid) chk("stall_hold", 32'(out_data), 32'(prev_data));
      if (out_valid && !out_ready && (idx % N) >= W+1) chk("stall_in_ready", 32'(in_ready), 32'(0));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (in_valid && in_ready) begin
        if (idx == W+1) acc9_cyc = cyc;
        if (idx == N)   next_frame_acc_cyc = cyc;
        idx++;
      end
      if (out_valid && out_ready) begin
        if (n_out < 2*N) begin
          got_pix[n_out] = out_data;
          got_sof[n_out] = out_sof;
          got_eol[n_out] = out_eol;
        end
        n_out++;
        last_hs = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("frames_done", 32'(n_fd), 32'(nframes));
    chk("inputs_taken", 32'(idx), 32'(npix));
  endtask

  task automatic verify(input string tag, input int nq);
    for (int q = 0; q < nq; q++) begin
      chk($sformatf("%s_data q=%0d", tag, q), 32'(got_pix[q]), 32'(exp_pix[q]));
      chk($sformatf("%s_sof q=%0d", tag, q), 32'(got_sof[q]), 32'((q % N) == 0));
      chk($sformatf("%s_eol q=%0d", tag, q), 32'(got_eol[q]), 32'((q % W) == W-1));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_sof", 32'(out_sof), 32'(0));
    chk("rst_out_eol", 32'(out_eol), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;

    // Mode 0 ramp
    for (int p = 0; p < N; p++) begin
      in_pix[p] = {3{4'(p % 16)}};
      in_md[p]  = 2'd0;
      exp_pix[p] = in_pix[p];
    end
    run_stream(N, 1, 1);
    chk("first_valid_lat", 32'(first_valid_cyc), 32'(acc9_cyc + 1));
    chk("ramp_count", 32'(n_out), 32'(N));
    verify("ramp", N);
    chk("fd_one_cycle", 32'(frame_done), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));

    // Single R=15 impulse at (3,2) in box, Gaussian, sharpen
    for (int m = 1; m <= 3; m++) begin
      for (int p = 0; p < N; p++) begin
        in_pix[p]  = (p == 2*W + 3) ? 12'hF00 : 12'h000;
        in_md[p]   = 2'(m);
        exp_pix[p] = imp_exp(m, p % W, p / W);
      end
      run_stream(N, 1, 1);
      verify($sformatf("impulse_m%0d", m), N);
    end

    // Random Gaussian frame, free-running then with out_ready 1 cycle in 3
    for (int p = 0; p < N; p++) begin
      in_pix[p] = 12'($urandom_range(0, 4095));
      in_md[p]  = 2'd2;
    end
    for (int p = 0; p < N; p++) exp_pix[p] = model(0, p % W, p / W, 2'd2);
    run_stream(N, 1, 1);
    verify("rand_nostall", N);
    run_stream(N, 3, 1);
    verify("rand_stall", N);

    // mode switched 1->3 mid-frame; next frame back-to-back in sharpen
    for (int p = 0; p < 2*N; p++) begin
      in_pix[p] = 12'($urandom_range(0, 4095));
      in_md[p]  = (p < 20) ? 2'd1 : 2'd3;
    end
    for (int p = 0; p < N; p++) begin
      exp_pix[p]     = model(0, p % W, p / W, 2'd1);
      exp_pix[N + p] = model(N, p % W, p / W, 2'd3);
    end
    run_stream(2*N, 1, 2);
    verify("mode_chg", 2*N);
    chk("back_to_back", 32'(next_frame_acc_cyc), 32'(fd_cyc));

    // Reset after 20 inputs, then a clean mode-0 frame
    for (int p = 0; p < N; p++) begin
      in_pix[p]  = 12'($urandom_range(0, 4095));
      in_md[p]   = 2'd0;
      exp_pix[p] = in_pix[p];
    end
    chk("pre_reset_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      in_data = in_pix[(i + 7) % N];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_reset_busy", 32'(busy), 32'(1));
    chk("pre_reset_valid", 32'(out_valid), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 32'(out_valid), 32'(0));
    chk("post_reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    run_stream(N, 1, 1);
    verify("post_reset", N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
